// File: rtl/seq_shifter_if.sv
// Handshake and data bundle between the control FSM and the sequential shifter.
// The master side issues a shift request and the slave side reports progress and the result.
interface seq_shifter_if #(
  parameter int WIDTH = 32
) ();
  localparam int SHAMT_W = $clog2(WIDTH);

  logic               start;
  logic [1:0]         mode;
  logic [SHAMT_W-1:0] shamt;
  logic [WIDTH-1:0]   dataIn;
  logic               busy;
  logic               done;
  logic [WIDTH-1:0]   result;

  modport master (
    output start, mode, shamt, dataIn,
    input  busy, done, result
  );

  modport slave (
    input  start, mode, shamt, dataIn,
    output busy, done, result
  );
endinterface

// File: rtl/seq_shifter.sv
// Multi-cycle shifter for the multi-cycle MIPS datapath.
// It performs SLL, SRL and SRA over WIDTH bits and moves at most STEP bit positions per clock.
// Optional macro SEQ_SHIFTER_ROTATE_EN makes mode 11 a rotate right.
// When the macro is not defined, mode 11 passes the operand through unchanged.
module seq_shifter #(
  parameter int WIDTH = 32,
  parameter int STEP  = 1
) (
  input logic         clk,
  input logic         reset,
  seq_shifter_if.slave bus
);
  localparam int SHAMT_W = $clog2(WIDTH);
  // STEP can equal WIDTH, so it needs one bit more than a shift count.
  localparam logic [SHAMT_W:0] STEP_EXT = (SHAMT_W + 1)'(STEP);

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    FINISH
  } stateT;

  stateT              state;
  stateT              nextState;
  logic [WIDTH-1:0]   work;
  logic [WIDTH-1:0]   shifted;
  logic [WIDTH-1:0]   resultReg;
  logic [SHAMT_W-1:0] cnt;
  logic [SHAMT_W-1:0] stepK;
  logic [SHAMT_W-1:0] startCnt;
  logic [1:0]         modeReg;
  logic               accept;
  logic               busyInt;
  logic               doneInt;
`ifdef SEQ_SHIFTER_ROTATE_EN
  logic [2*WIDTH-1:0] rotPair;
`endif

  assign bus.busy   = busyInt;
  assign bus.done   = doneInt;
  assign bus.result = resultReg;

  // Number of positions still to shift when the request is accepted. A non-rotating build turns mode 11 into a zero-length pass-through.
  always_comb begin
    startCnt = bus.shamt;
`ifndef SEQ_SHIFTER_ROTATE_EN
    if (bus.mode == 2'b11) begin
      startCnt = '0;
    end
`endif
  end

  // This cycle's step is the smaller of STEP and the remaining count.
  always_comb begin
    stepK = cnt;
    if ({1'b0, cnt} > STEP_EXT) begin
      stepK = STEP_EXT[SHAMT_W-1:0];
    end
  end

  // One shift step applied to the working value, using the latched mode.
  always_comb begin
    shifted = work;
`ifdef SEQ_SHIFTER_ROTATE_EN
    rotPair = {work, work} >> stepK;
`endif
    case (modeReg)
      2'b00:   shifted = work << stepK;
      2'b01:   shifted = work >> stepK;
      2'b10:   shifted = $signed(work) >>> stepK;
`ifdef SEQ_SHIFTER_ROTATE_EN
      default: shifted = rotPair[WIDTH-1:0];
`else
      default: shifted = work;
`endif
    endcase
  end

  // Next-state logic plus busy and done. A start is accepted in IDLE or FINISH so that back-to-back requests have no idle cycle between them.
  always_comb begin
    nextState = state;
    busyInt   = 1'b0;
    doneInt   = 1'b0;
    accept    = 1'b0;
    case (state)
      IDLE, FINISH: begin
        doneInt = (state == FINISH);
        if (bus.start) begin
          accept    = 1'b1;
          nextState = (startCnt != '0) ? SHIFT : FINISH;
        end else begin
          nextState = IDLE;
        end
      end
      SHIFT: begin
        busyInt = 1'b1;
        if (cnt == stepK) begin
          nextState = FINISH;
        end
      end
      default: nextState = IDLE;
    endcase
  end

  // State register. A reset abandons any operation that is in flight.
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= nextState;
    end
  end

  // Operand latch, stepping of the working value, and result capture on entry to FINISH.
  always_ff @(posedge clk) begin
    if (reset) begin
      work      <= '0;
      cnt       <= '0;
      modeReg   <= '0;
      resultReg <= '0;
    end else if (accept) begin
      work    <= bus.dataIn;
      cnt     <= startCnt;
      modeReg <= bus.mode;
      if (startCnt == '0) begin
        resultReg <= bus.dataIn;
      end
    end else if (state == SHIFT) begin
      work <= shifted;
      cnt  <= cnt - stepK;
      if (cnt == stepK) begin
        resultReg <= shifted;
      end
    end
  end
endmodule

// File: tb/tb_seq_shifter.sv
// Bench for seq_shifter. It instantiates two copies of the shifter: one with STEP=1 and one with STEP=8.
// A behavioural model derives every cycle's busy, done and result values from the shift operators and the step latency.
// Directed vectors with hand-computed literals pin both the model and the design.
module tb_seq_shifter;
  logic clk;
  logic reset;
  int   errors;
  int   checks;
  bit   checkEn;

  seq_shifter_if #(.WIDTH(32)) busStep1 ();
  seq_shifter_if #(.WIDTH(32)) busStep8 ();

  seq_shifter #(.WIDTH(32), .STEP(1)) dutStep1 (.clk(clk), .reset(reset), .bus(busStep1));
  seq_shifter #(.WIDTH(32), .STEP(8)) dutStep8 (.clk(clk), .reset(reset), .bus(busStep8));

  // Free-running clock.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Watchdog so the run always ends even if the bench itself hangs.
  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  // Reference operation computed with the single-shot operators.
  function automatic logic [31:0] refOp(input logic [1:0] md, input int sh, input logic [31:0] a);
    case (md)
      2'b00:   return a << sh;
      2'b01:   return a >> sh;
      2'b10:   return $signed(a) >>> sh;
`ifdef SEQ_SHIFTER_ROTATE_EN
      default: return (a >> sh) | ((sh == 0) ? 32'h0 : (a << (32 - sh)));
`else
      default: return a;
`endif
    endcase
  endfunction

  // Number of busy cycles: ceil(shamt/STEP), or zero for a pass-through.
  function automatic int refSteps(input logic [1:0] md, input int sh, input int step);
`ifndef SEQ_SHIFTER_ROTATE_EN
    if (md == 2'b11) return 0;
`endif
    return (sh + step - 1) / step;
  endfunction

  int          mBusyLeft[2];
  bit          mDone[2];
  logic [31:0] mResult[2];
  logic [31:0] mPending[2];
  logic        sStart[2];
  logic [1:0]  sMode[2];
  logic [4:0]  sShamt[2];
  logic [31:0] sData[2];
  int          stepOf[2];

  // Model update at every rising edge. While an operation is busy, a countdown records how many cycles remain.
  always @(posedge clk) begin
    stepOf[0] = 1;
    stepOf[1] = 8;
    sStart[0] = busStep1.start; sMode[0] = busStep1.mode; sShamt[0] = busStep1.shamt; sData[0] = busStep1.dataIn;
    sStart[1] = busStep8.start; sMode[1] = busStep8.mode; sShamt[1] = busStep8.shamt; sData[1] = busStep8.dataIn;
    for (int i = 0; i < 2; i++) begin
      if (reset) begin
        mBusyLeft[i] <= 0;
        mDone[i]     <= 1'b0;
        mResult[i]   <= 32'h0;
      end else if (mBusyLeft[i] == 0) begin
        mDone[i] <= 1'b0;
        if (sStart[i] === 1'b1) begin
          if (refSteps(sMode[i], int'(sShamt[i]), stepOf[i]) == 0) begin
            mDone[i]   <= 1'b1;
            mResult[i] <= refOp(sMode[i], int'(sShamt[i]), sData[i]);
          end else begin
            mBusyLeft[i] <= refSteps(sMode[i], int'(sShamt[i]), stepOf[i]);
            mPending[i]  <= refOp(sMode[i], int'(sShamt[i]), sData[i]);
          end
        end
      end else begin
        mBusyLeft[i] <= mBusyLeft[i] - 1;
        if (mBusyLeft[i] == 1) begin
          mDone[i]   <= 1'b1;
          mResult[i] <= mPending[i];
        end
      end
    end
  end

  // Every cycle, compare both DUTs with the model on the falling edge.
  always @(negedge clk) begin
    if (checkEn) begin
      logic        aBusy[2];
      logic        aDone[2];
      logic [31:0] aResult[2];
      aBusy[0] = busStep1.busy; aDone[0] = busStep1.done; aResult[0] = busStep1.result;
      aBusy[1] = busStep8.busy; aDone[1] = busStep8.done; aResult[1] = busStep8.result;
      for (int i = 0; i < 2; i++) begin
        checks = checks + 3;
        if (aBusy[i] !== (mBusyLeft[i] != 0)) begin
          errors = errors + 1;
          $display("[TB] FAIL busy[%0d] t=%0t: got %b want %b", i, $time, aBusy[i], mBusyLeft[i] != 0);
        end
        if (aDone[i] !== mDone[i]) begin
          errors = errors + 1;
          $display("[TB] FAIL done[%0d] t=%0t: got %b want %b", i, $time, aDone[i], mDone[i]);
        end
        if (aResult[i] !== mResult[i]) begin
          errors = errors + 1;
          $display("[TB] FAIL result[%0d] t=%0t: got 0x%08h want 0x%08h", i, $time, aResult[i], mResult[i]);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic driveInputs(input int which, input logic st, input logic [1:0] md, input logic [4:0] sh, input logic [31:0] d);
    if (which == 0) begin
      busStep1.start = st; busStep1.mode = md; busStep1.shamt = sh; busStep1.dataIn = d;
    end else begin
      busStep8.start = st; busStep8.mode = md; busStep8.shamt = sh; busStep8.dataIn = d;
    end
  endtask

  task automatic readOut(input int which, output logic busy, output logic done, output logic [31:0] result);
    if (which == 0) begin
      busy = busStep1.busy; done = busStep1.done; result = busStep1.result;
    end else begin
      busy = busStep8.busy; done = busStep8.done; result = busStep8.result;
    end
  endtask

  task automatic checkOutput(input string name, input logic [31:0] got, input logic [31:0] want);
    checks = checks + 1;
    if (got !== want) begin
      errors = errors + 1;
      $display("[TB] FAIL %s: got 0x%08h want 0x%08h", name, got, want);
    end
  endtask

  // Issue one request. Then wait a bounded number of cycles for done and count the cycles and busy cycles after the accepting edge.
  // If poke is set, a different request is offered while the shifter is busy.
  task automatic applyStimulus(input int which, input logic [1:0] md, input logic [4:0] sh, input logic [31:0] d,
                               input bit poke, output int lat, output int busyCnt, output logic [31:0] res);
    logic b;
    logic dn;
    bit   seen;
    driveInputs(which, 1'b1, md, sh, d);
    tick();
    driveInputs(which, 1'b0, md, sh, d);
    lat = 0;
    busyCnt = 0;
    seen = 1'b0;
    res = 32'h0;
    for (int n = 0; n < 64; n++) begin
      readOut(which, b, dn, res);
      if (dn === 1'b1) begin
        seen = 1'b1;
        break;
      end
      if (b === 1'b1) busyCnt++;
      if (poke && lat == 1) driveInputs(which, 1'b1, 2'b00, 5'd3, 32'h0000_1234);
      else driveInputs(which, 1'b0, md, sh, d);
      tick();
      lat++;
    end
    driveInputs(which, 1'b0, md, sh, d);
    if (!seen) begin
      checks = checks + 1;
      errors = errors + 1;
      $display("[TB] FAIL doneTimeout: got no done want done within 64 cycles");
    end
    tick();
  endtask

  initial begin
    int          lat;
    int          bc;
    logic [31:0] res;
    logic        b;
    logic        dn;
    int          doneSeen;
    logic [1:0]  modes[4];
    errors  = 0;
    checks  = 0;
    checkEn = 1'b0;
    reset   = 1'b1;
    driveInputs(0, 1'b0, 2'b00, 5'd0, 32'h0);
    driveInputs(1, 1'b0, 2'b00, 5'd0, 32'h0);
    tick();
    checkEn = 1'b1;
    tick();
    tick();
    readOut(0, b, dn, res);
    checkOutput("resetBusy", {31'h0, b}, 32'h0);
    checkOutput("resetDone", {31'h0, dn}, 32'h0);
    checkOutput("resetResult", res, 32'h0);
    reset = 1'b0;
    tick();

    applyStimulus(0, 2'b00, 5'd2, 32'h0000_000A, 1'b0, lat, bc, res);
    checkOutput("sllResult", res, 32'h0000_0028);
    checkOutput("sllLatency", 32'(lat), 32'd2);
    checkOutput("sllBusyCycles", 32'(bc), 32'd2);

    applyStimulus(0, 2'b10, 5'd4, 32'h8000_0010, 1'b0, lat, bc, res);
    checkOutput("sraResult", res, 32'hF800_0001);
    applyStimulus(0, 2'b01, 5'd4, 32'h8000_0010, 1'b0, lat, bc, res);
    checkOutput("srlResult", res, 32'h0800_0001);

    modes[0] = 2'b00; modes[1] = 2'b01; modes[2] = 2'b10; modes[3] = 2'b11;
    for (int m = 0; m < 4; m++) begin
      applyStimulus(0, modes[m], 5'd0, 32'hDEAD_BEEF, 1'b0, lat, bc, res);
      checkOutput($sformatf("zeroShamtResult%0d", m), res, 32'hDEAD_BEEF);
      checkOutput($sformatf("zeroShamtLatency%0d", m), 32'(lat), 32'd0);
      checkOutput($sformatf("zeroShamtBusy%0d", m), 32'(bc), 32'd0);
    end

    applyStimulus(1, 2'b01, 5'd31, 32'hFFFF_FFFF, 1'b1, lat, bc, res);
    checkOutput("step8Result", res, 32'h0000_0001);
    checkOutput("step8Latency", 32'(lat), 32'd4);
    checkOutput("step8BusyCycles", 32'(bc), 32'd4);

    applyStimulus(1, 2'b00, 5'd9, 32'h1234_5678, 1'b0, lat, bc, res);
    checkOutput("step8Sll9", res, 32'h68AC_F000);
    applyStimulus(1, 2'b10, 5'd17, 32'h9000_0000, 1'b0, lat, bc, res);
    checkOutput("step8Sra17", res, 32'hFFFF_C800);
    applyStimulus(1, 2'b01, 5'd8, 32'hA5A5_A5A5, 1'b0, lat, bc, res);
    checkOutput("step8Srl8", res, 32'h00A5_A5A5);
    checkOutput("step8Srl8Latency", 32'(lat), 32'd1);

    applyStimulus(0, 2'b11, 5'd4, 32'h0000_000F, 1'b0, lat, bc, res);
`ifdef SEQ_SHIFTER_ROTATE_EN
    checkOutput("mode11Result", res, 32'hF000_0000);
    checkOutput("mode11Latency", 32'(lat), 32'd4);
`else
    checkOutput("mode11Result", res, 32'h0000_000F);
    checkOutput("mode11Latency", 32'(lat), 32'd0);
`endif

    // Keep start high through FINISH. A second operation follows with no idle cycle in between.
    driveInputs(0, 1'b1, 2'b00, 5'd1, 32'h0000_0001);
    tick();
    driveInputs(0, 1'b1, 2'b01, 5'd0, 32'h0000_0055);
    tick();
    readOut(0, b, dn, res);
    checkOutput("b2bFirstDone", {31'h0, dn}, 32'h1);
    checkOutput("b2bFirstResult", res, 32'h0000_0002);
    tick();
    driveInputs(0, 1'b0, 2'b00, 5'd0, 32'h0);
    readOut(0, b, dn, res);
    checkOutput("b2bSecondDone", {31'h0, dn}, 32'h1);
    checkOutput("b2bSecondResult", res, 32'h0000_0055);
    tick();
    readOut(0, b, dn, res);
    checkOutput("b2bIdleDone", {31'h0, dn}, 32'h0);

    // Assert reset in the middle of a long shift.
    driveInputs(0, 1'b1, 2'b00, 5'd20, 32'h0000_0003);
    tick();
    driveInputs(0, 1'b0, 2'b00, 5'd20, 32'h0000_0003);
    for (int n = 0; n < 5; n++) tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    readOut(0, b, dn, res);
    checkOutput("abortBusy", {31'h0, b}, 32'h0);
    checkOutput("abortDone", {31'h0, dn}, 32'h0);
    checkOutput("abortResult", res, 32'h0);
    doneSeen = 0;
    for (int n = 0; n < 30; n++) begin
      tick();
      readOut(0, b, dn, res);
      if (dn !== 1'b0) doneSeen++;
    end
    checkOutput("abortNoLateDone", 32'(doneSeen), 32'd0);

    tick();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
